// File: rtl/fpu_operand_stage_if.sv
// Instruction-issue handshake plus the integer-side (mtc1/mfc1) register file port.
// The issuing side is the master; the operand stage is the slave.
interface fpu_operand_stage_if #(
  parameter int NREG = 32,
  parameter int DW   = 32
);
  localparam int AW = $clog2(NREG);

  logic          issue_valid;
  logic          issue_ready;
  logic [5:0]    issue_op;
  logic [AW-1:0] issue_fs;
  logic [AW-1:0] issue_ft;
  logic [AW-1:0] issue_fd;

  logic          ext_wr_en;
  logic          ext_wr_ready;
  logic [AW-1:0] ext_wr_addr;
  logic [DW-1:0] ext_wr_data;
  logic [AW-1:0] ext_rd_addr;
  logic [DW-1:0] ext_rd_data;

  modport master (
    output issue_valid, issue_op, issue_fs, issue_ft, issue_fd,
    output ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr,
    input  issue_ready, ext_wr_ready, ext_rd_data
  );

  modport slave (
    input  issue_valid, issue_op, issue_fs, issue_ft, issue_fd,
    input  ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr,
    output issue_ready, ext_wr_ready, ext_rd_data
  );
endinterface

// File: rtl/fpu_operand_stage.sv
// Four-state sequencer around a combinational FPU: IDLE -> READ -> EXEC -> WB.
// Owns the FP register file and the condition-code flag.
module fpu_operand_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_operand_stage_if.slave   bus,
  output logic [DW-1:0]        fpu_inp1,
  output logic [DW-1:0]        fpu_inp2,
  output logic [5:0]           fpu_opcode,
  input  logic [DW-1:0]        fpu_out,
  input  logic                 fpu_cc,
  output logic                 cc_flag,
  output logic                 done,
  output logic                 illegal_op
);
  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_ADD = 6'b100010;
  localparam logic [5:0] OP_SUB = 6'b100011;
  localparam logic [5:0] OP_CEQ = 6'b100100;
  localparam logic [5:0] OP_CLE = 6'b100101;
  localparam logic [5:0] OP_CLT = 6'b100110;
  localparam logic [5:0] OP_CGE = 6'b100111;
  localparam logic [5:0] OP_CGT = 6'b101000;
  localparam logic [5:0] OP_MOV = 6'b101001;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  typedef enum logic [1:0] {K_ILL, K_ARITH, K_CMP} kind_t;

  typedef struct packed {
    logic [5:0]    op;
    logic [AW-1:0] fs;
    logic [AW-1:0] ft;
    logic [AW-1:0] fd;
  } instr_t;

  state_t                  state, state_nx;
  instr_t                  ins;
  kind_t                   kind;
  logic [NREG-1:0][DW-1:0] rf;
  logic [DW-1:0]           opa, opb, opa_nx, opb_nx, res;
  logic                    res_cc;
  logic                    accept, ext_wr;

  // FSM outputs and next state
  always_comb begin
    state_nx         = state;
    bus.issue_ready  = 1'b0;
    bus.ext_wr_ready = 1'b1;
    done             = 1'b0;
    illegal_op       = 1'b0;
    case (state)
      IDLE: begin
        bus.issue_ready = 1'b1;
        if (bus.issue_valid) state_nx = READ;
      end
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB: begin
        // WB owns the single regfile write port this cycle
        bus.ext_wr_ready = 1'b0;
        done             = 1'b1;
        illegal_op       = (kind == K_ILL);
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (ins.op)
      OP_ADD, OP_SUB, OP_MOV:                 kind = K_ARITH;
      OP_CEQ, OP_CLE, OP_CLT, OP_CGE, OP_CGT: kind = K_CMP;
      default:                                kind = K_ILL;
    endcase
  end

  assign accept = bus.issue_valid & bus.issue_ready;
  assign ext_wr = bus.ext_wr_en & bus.ext_wr_ready;

  // An mtc1 landing on the read edge is forwarded so the op sees the new value
  assign opa_nx = (ext_wr && bus.ext_wr_addr == ins.fs) ? bus.ext_wr_data : rf[ins.fs];
  assign opb_nx = (ext_wr && bus.ext_wr_addr == ins.ft) ? bus.ext_wr_data : rf[ins.ft];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ins     <= '0;
      opa     <= '0;
      opb     <= '0;
      res     <= '0;
      res_cc  <= 1'b0;
      cc_flag <= 1'b0;
      rf      <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        ins <= '{op: bus.issue_op, fs: bus.issue_fs, ft: bus.issue_ft, fd: bus.issue_fd};
      if (state == READ) begin
        opa <= opa_nx;
        opb <= opb_nx;
      end
      if (state == EXEC) begin
        res    <= fpu_out;
        res_cc <= fpu_cc;
      end
      if (state == WB && kind == K_CMP)
        cc_flag <= res_cc;
      if (state == WB && kind == K_ARITH)
        rf[ins.fd] <= res;
      else if (ext_wr)
        rf[bus.ext_wr_addr] <= bus.ext_wr_data;
    end
  end

  assign fpu_inp1        = opa;
  assign fpu_inp2        = opb;
  assign fpu_opcode      = ins.op;
  assign bus.ext_rd_data = rf[bus.ext_rd_addr];

endmodule

// File: tb/tb_fpu_operand_stage.sv
// Bench for fpu_operand_stage: behavioural FPU stand-in, transaction-level regfile/cc model,
// directed table, hand sequences for hold-off/bypass/reset, then randomized ops.
module tb_fpu_operand_stage;
  localparam logic [5:0] ADD = 6'b100010, SUB = 6'b100011, CEQ = 6'b100100, CLE = 6'b100101;
  localparam logic [5:0] CLT = 6'b100110, CGE = 6'b100111, CGT = 6'b101000, MOV = 6'b101001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fpu_inp1, fpu_inp2, fpu_out;
  logic [5:0]  fpu_opcode;
  logic        fpu_cc, cc_flag, done, illegal_op;

  always #5 clk = ~clk;

  fpu_operand_stage_if bus ();

  fpu_operand_stage dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fpu_inp1   (fpu_inp1),
    .fpu_inp2   (fpu_inp2),
    .fpu_opcode (fpu_opcode),
    .fpu_out    (fpu_out),
    .fpu_cc     (fpu_cc),
    .cc_flag    (cc_flag),
    .done       (done),
    .illegal_op (illegal_op)
  );

  typedef struct packed {logic [31:0] v; logic cc;} fres_t;

  function automatic real s2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic fres_t fpu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    fres_t f;
    real   x, y;
    x = s2r(a);
    y = s2r(b);
    f = '0;
    case (op)
      ADD: f.v = r2s(x + y);
      SUB: f.v = r2s(x - y);
      MOV: f.v = a;
      CEQ: f.cc = (x == y);
      CLE: f.cc = (x <= y);
      CLT: f.cc = (x < y);
      CGE: f.cc = (x >= y);
      CGT: f.cc = (x > y);
      default: ;
    endcase
    return f;
  endfunction

  fres_t fr;
  assign fr      = fpu_fn(fpu_opcode, fpu_inp1, fpu_inp2);
  assign fpu_out = fr.v;
  assign fpu_cc  = fr.cc;

  logic [31:0] rf_m [32];
  logic        cc_m;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int kind_of(input logic [5:0] op);
    if (op == ADD || op == SUB || op == MOV) return 1;
    if (op >= CEQ && op <= CGT) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom_range(1, 0)), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  task automatic mtc1(input logic [4:0] a, input logic [31:0] d);
    bus.ext_wr_en = 1'b1; bus.ext_wr_addr = a; bus.ext_wr_data = d;
    chk("mtc1_ready", 32'(bus.ext_wr_ready), 32'd1);
    tick;
    bus.ext_wr_en = 1'b0;
    rf_m[a] = d;
  endtask

  task automatic ext_drive(input logic [4:0] a, input logic [31:0] d);
    bus.ext_wr_en = 1'b1; bus.ext_wr_addr = a; bus.ext_wr_data = d;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.ext_rd_addr = a;
    #1;
    chk(name, bus.ext_rd_data, exp);
  endtask

  // One full instruction; wr_cyc: 0 none, 1 READ, 2 EXEC, 3 WB (mtc1 in that cycle)
  task automatic run_op(input logic [5:0] op, input logic [4:0] fs, input logic [4:0] ft,
                        input logic [4:0] fd, input int wr_cyc, input logic [4:0] wa,
                        input logic [31:0] wd, output logic ill_seen);
    logic [31:0] a, b, wa_old;
    fres_t r;
    int k;
    k = kind_of(op);
    bus.issue_op = op; bus.issue_fs = fs; bus.issue_ft = ft; bus.issue_fd = fd;
    bus.issue_valid = 1'b1;
    chk("ready_idle", 32'(bus.issue_ready), 32'd1);
    tick;
    bus.issue_valid = 1'b0;
    chk("ready_read", 32'(bus.issue_ready), 32'd0);
    chk("done_read", 32'(done), 32'd0);
    if (wr_cyc == 1) begin
      chk("wr_ready_read", 32'(bus.ext_wr_ready), 32'd1);
      ext_drive(wa, wd); rf_m[wa] = wd;
    end
    a = rf_m[fs];
    b = rf_m[ft];
    tick;
    bus.ext_wr_en = 1'b0;
    chk("fpu_inp1", fpu_inp1, a);
    chk("fpu_inp2", fpu_inp2, b);
    chk("fpu_opcode", 32'(fpu_opcode), 32'(op));
    chk("done_exec", 32'(done), 32'd0);
    if (wr_cyc == 2) begin ext_drive(wa, wd); rf_m[wa] = wd; end
    tick;
    bus.ext_wr_en = 1'b0;
    chk("done_wb", 32'(done), 32'd1);
    ill_seen = illegal_op;
    chk("illegal_wb", 32'(illegal_op), 32'(k == 0));
    chk("wr_ready_wb", 32'(bus.ext_wr_ready), 32'd0);
    chk("ready_wb", 32'(bus.issue_ready), 32'd0);
    rd_chk("wb_old_value", fd, rf_m[fd]);
    wa_old = rf_m[wa];
    if (wr_cyc == 3) ext_drive(wa, wd);
    r = fpu_fn(op, a, b);
    if (k == 1) rf_m[fd] = r.v;
    else if (k == 2) cc_m = r.cc;
    tick;
    bus.ext_wr_en = 1'b0;
    chk("done_after", 32'(done), 32'd0);
    chk("illegal_after", 32'(illegal_op), 32'd0);
    chk("ready_after", 32'(bus.issue_ready), 32'd1);
    chk("cc_flag", 32'(cc_flag), 32'(cc_m));
    rd_chk("fd_result", fd, rf_m[fd]);
    if (wr_cyc == 3 && wa != fd) rd_chk("wb_ext_dropped", wa, wa_old);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  fs, ft, fd, ca;
    logic [31:0] ev;
    logic        ecc, eill;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic ill;
    logic [5:0] op;
    logic [4:0] fs, wa;
    rst = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_fs = '0; bus.issue_ft = '0; bus.issue_fd = '0;
    bus.ext_wr_en = 1'b0; bus.ext_wr_addr = '0; bus.ext_wr_data = '0; bus.ext_rd_addr = '0;
    foreach (rf_m[i]) rf_m[i] = '0;
    cc_m = 1'b0;

    tbl[0] = '{ADD,       5'd1, 5'd2, 5'd3, 5'd3, 32'h40400000, 1'b0, 1'b0};
    tbl[1] = '{CLT,       5'd1, 5'd2, 5'd9, 5'd9, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{CGT,       5'd1, 5'd2, 5'd9, 5'd3, 32'h40400000, 1'b0, 1'b0};
    tbl[3] = '{MOV,       5'd2, 5'd0, 5'd5, 5'd5, 32'h40000000, 1'b0, 1'b0};
    tbl[4] = '{SUB,       5'd2, 5'd1, 5'd6, 5'd6, 32'h3F800000, 1'b0, 1'b0};
    tbl[5] = '{CEQ,       5'd3, 5'd3, 5'd6, 5'd6, 32'h3F800000, 1'b1, 1'b0};
    tbl[6] = '{6'b000000, 5'd1, 5'd2, 5'd1, 5'd1, 32'h3F800000, 1'b1, 1'b1};
    tbl[7] = '{CGE,       5'd1, 5'd2, 5'd2, 5'd2, 32'h40000000, 1'b0, 1'b0};
    tbl[8] = '{CLE,       5'd1, 5'd2, 5'd3, 5'd3, 32'h40400000, 1'b1, 1'b0};
    tbl[9] = '{6'b111111, 5'd1, 5'd2, 5'd3, 5'd3, 32'h40400000, 1'b1, 1'b1};

    tick; tick;
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_inp1", fpu_inp1, 32'd0);
    chk("rst_inp2", fpu_inp2, 32'd0);
    chk("rst_opcode", 32'(fpu_opcode), 32'd0);
    chk("rst_cc", 32'(cc_flag), 32'd0);
    rd_chk("rst_rf0", 5'd0, 32'd0);
    rst = 1'b0;
    tick;

    // directed table
    mtc1(5'd1, 32'h3F800000);
    mtc1(5'd2, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].fs, tbl[i].ft, tbl[i].fd, 0, 5'd0, 32'd0, ill);
      rd_chk("tbl_data", tbl[i].ca, tbl[i].ev);
      chk("tbl_cc", 32'(cc_flag), 32'(tbl[i].ecc));
      chk("tbl_illegal", 32'(ill), 32'(tbl[i].eill));
    end

    // mtc1 in READ is forwarded into the operand
    run_op(ADD, 5'd1, 5'd2, 5'd3, 1, 5'd1, 32'h40800000, ill);
    rd_chk("bypass_f3", 5'd3, 32'h40C00000);
    rd_chk("bypass_f1", 5'd1, 32'h40800000);
    // mtc1 to fd in EXEC is overwritten by WB
    run_op(ADD, 5'd1, 5'd2, 5'd4, 2, 5'd4, 32'h12345678, ill);
    rd_chk("inflight_f4", 5'd4, 32'h40C00000);
    // mtc1 in WB is refused
    run_op(MOV, 5'd2, 5'd0, 5'd7, 3, 5'd8, 32'hDEADBEEF, ill);
    rd_chk("wb_drop_f8", 5'd8, 32'd0);

    // held issue_valid: second op waits until IDLE
    bus.issue_op = ADD; bus.issue_fs = 5'd1; bus.issue_ft = 5'd2; bus.issue_fd = 5'd8;
    bus.issue_valid = 1'b1;
    tick;
    bus.issue_op = MOV; bus.issue_fs = 5'd3; bus.issue_ft = 5'd0; bus.issue_fd = 5'd10;
    for (int c = 0; c < 3; c++) begin
      chk("held_ready_busy", 32'(bus.issue_ready), 32'd0);
      chk("held_done", 32'(done), 32'(c == 2));
      tick;
    end
    chk("held_ready_idle", 32'(bus.issue_ready), 32'd1);
    rf_m[8] = fpu_fn(ADD, rf_m[1], rf_m[2]).v;
    rd_chk("held_first_result", 5'd8, rf_m[8]);
    tick;
    bus.issue_valid = 1'b0;
    chk("held_second_accepted", 32'(bus.issue_ready), 32'd0);
    tick; tick;
    chk("held_second_done", 32'(done), 32'd1);
    tick;
    rf_m[10] = rf_m[3];
    rd_chk("held_second_result", 5'd10, 32'h40C00000);

    // reset while in EXEC abandons the op
    run_op(CEQ, 5'd1, 5'd1, 5'd0, 0, 5'd0, 32'd0, ill);
    chk("pre_rst_cc", 32'(cc_flag), 32'd1);
    bus.issue_op = ADD; bus.issue_fs = 5'd1; bus.issue_ft = 5'd2; bus.issue_fd = 5'd11;
    bus.issue_valid = 1'b1;
    tick;
    bus.issue_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_ready", 32'(bus.issue_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cc", 32'(cc_flag), 32'd0);
    rd_chk("midrst_fd", 5'd11, 32'd0);
    tick;
    chk("midrst_no_done1", 32'(done), 32'd0);
    tick;
    chk("midrst_no_done2", 32'(done), 32'd0);
    foreach (rf_m[i]) rf_m[i] = '0;
    cc_m = 1'b0;

    // randomized ops against the model
    for (int r = 0; r < 32; r++) mtc1(5'(r), rnd_f());
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(9, 0))
        0: op = ADD; 1: op = SUB; 2: op = MOV; 3: op = CEQ; 4: op = CLE;
        5: op = CLT; 6: op = CGE; 7: op = CGT;
        default: op = 6'($urandom);
      endcase
      fs = 5'($urandom);
      wa = $urandom_range(1, 0) ? fs : 5'($urandom);
      run_op(op, fs, 5'($urandom), 5'($urandom), int'($urandom_range(3, 0)), wa, rnd_f(), ill);
      if ($urandom_range(3, 0) == 0) mtc1(5'($urandom), rnd_f());
    end
    for (int r = 0; r < 32; r++) rd_chk("final_rf", 5'(r), rf_m[r]);
    chk("final_cc", 32'(cc_flag), 32'(cc_m));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
